// File: rtl/pixel_stream_gen.sv
// pixel_stream_gen: raster 10-bit pixel source with H/V blanking, selectable
// test patterns, start/stop control and frame counting.
// Optional feature: define PIX_GEN_STALL_EN to add the iSTALL input, which
// holds the current pixel and drops oDVAL while ACTIVE.
module pixel_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [1:0]  iMODE,
  input  logic [9:0]  iLEVEL,
`ifdef PIX_GEN_STALL_EN
  input  logic        iSTALL,
`endif
  output logic        oDVAL,
  output logic [9:0]  oDATA,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic        oFRAME_DONE,
  output logic [15:0] oFrameCount,
  output logic        oBUSY
);

  localparam logic [15:0] X_LAST  = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_ACTIVE - 1);
  localparam logic [31:0] HB_LAST = 32'(H_BLANK - 1);
  localparam logic [31:0] VB_LAST = 32'(V_BLANK * (H_ACTIVE + H_BLANK) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [31:0] r_bcnt, w_bcnt_nxt;
  logic [1:0]  r_mode;
  logic [9:0]  r_level;
  logic        r_stop;
  logic        w_latch, w_dval_nxt, w_done_nxt, w_stall;

`ifdef PIX_GEN_STALL_EN
  assign w_stall = iSTALL;
`else
  assign w_stall = 1'b0;
`endif

  // Test-pattern value for one pixel under the latched mode.
  function automatic logic [9:0] pix(input logic [1:0] mode, input logic [9:0] level,
                                     input logic [9:0] x, input logic [9:0] y);
    logic [9:0] v;
    case (mode)
      2'd0:    v = level;
      2'd1:    v = x;
      2'd2:    v = (x[3] ^ y[3]) ? 10'd1023 : 10'd0;
      default: v = y;
    endcase
    return v;
  endfunction

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, raster counter updates and per-cycle strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_bcnt_nxt  = r_bcnt;
    w_latch     = 1'b0;
    w_dval_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (iSTART) begin
          w_state_nxt = S_ACTIVE;
          w_x_nxt     = 16'd0;
          w_y_nxt     = 16'd0;
          w_latch     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!w_stall) begin
          w_dval_nxt = 1'b1;
          if (r_x == X_LAST) begin
            w_state_nxt = S_HBLANK;
            w_bcnt_nxt  = 32'd0;
          end else begin
            w_x_nxt = r_x + 16'd1;
          end
        end
      end
      S_HBLANK: begin
        if (r_bcnt == HB_LAST) begin
          w_bcnt_nxt = 32'd0;
          if (r_y < Y_LAST) begin
            w_state_nxt = S_ACTIVE;
            w_x_nxt     = 16'd0;
            w_y_nxt     = r_y + 16'd1;
          end else begin
            w_state_nxt = S_VBLANK;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 32'd1;
        end
      end
      S_VBLANK: begin
        if (r_bcnt == VB_LAST) begin
          w_done_nxt = 1'b1;
          // A stop arriving on this very edge still ends the run here.
          if (r_stop || iSTOP) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_ACTIVE;
            w_x_nxt     = 16'd0;
            w_y_nxt     = 16'd0;
            w_latch     = 1'b1;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 32'd1;
        end
      end
    endcase
  end

  // Raster counters, latched pattern selection and stop latch.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_bcnt  <= 32'd0;
      r_mode  <= 2'd0;
      r_level <= 10'd0;
      r_stop  <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_bcnt <= w_bcnt_nxt;
      if (w_latch) begin
        r_mode  <= iMODE;
        r_level <= iLEVEL;
      end
      if (w_state_nxt == S_IDLE)
        r_stop <= 1'b0;
      else if (r_state != S_IDLE && iSTOP)
        r_stop <= 1'b1;
    end
  end

  // Registered stream and status outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oDVAL       <= 1'b0;
      oDATA       <= 10'd0;
      oX          <= 16'd0;
      oY          <= 16'd0;
      oFRAME_DONE <= 1'b0;
      oFrameCount <= 16'd0;
      oBUSY       <= 1'b0;
    end else begin
      oDVAL       <= w_dval_nxt;
      oFRAME_DONE <= w_done_nxt;
      oBUSY       <= (r_state != S_IDLE);
      if (w_dval_nxt) begin
        oDATA <= pix(r_mode, r_level, r_x[9:0], r_y[9:0]);
        oX    <= r_x;
        oY    <= r_y;
      end else begin
        oDATA <= 10'd0;
      end
      if (w_done_nxt)
        oFrameCount <= oFrameCount + 16'd1;
    end
  end

endmodule

// File: doc/pixel_stream_gen.md
# pixel_stream_gen

Raster pixel-stream source for the capture pipeline. It produces frames of 10-bit pixels with a per-pixel data-valid strobe, in X-then-Y raster order, with horizontal and vertical blanking. It drives the same oDVAL/oDATA stream that the crop and counting stages consume, so those stages can be exercised in simulation and on the board without a sensor. Test patterns are selectable, and start, stop and frame-count status are available to the control logic.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 16, idle cycles after every active line (≥1)
- V_BLANK, 2, idle line-periods of (H_ACTIVE+H_BLANK) cycles after the last line (≥1)

Ports:
- iCLK  in  1  clock, rising edge
- iRST  in  1  reset, asynchronous, active-low
- iSTART  in  1  level sampled each edge; starts continuous frame generation from IDLE
- iSTOP  in  1  level sampled each edge; finish the current frame, then go to IDLE
- iMODE  in  2  pattern select: 0 constant, 1 horizontal ramp, 2 checkerboard, 3 vertical ramp
- iLEVEL  in  10  pixel value for mode 0
- oDVAL  out  1  pixel valid
- oDATA  out  10  pixel value; 0 whenever oDVAL=0
- oX  out  16  column of the current oDATA
- oY  out  16  row of the current oDATA
- oFRAME_DONE  out  1  one-cycle pulse concurrent with the last blanking cycle of each frame
- oFrameCount  out  16  completed frames since reset, wraps at 65535→0
- oBUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered. Reset values: oDVAL=0, oDATA=0, oX=0, oY=0, oFRAME_DONE=0, oFrameCount=0, oBUSY=0. Internal state goes to IDLE and the stop latch clears.
- States:
  - IDLE: stream low. iSTART=1 → ACTIVE with X=Y=0. iMODE and iLEVEL are latched at this moment.
  - ACTIVE: each cycle emit pixel (X,Y) with oDVAL=1, then X+1. After X=H_ACTIVE-1 → HBLANK.
  - HBLANK: oDVAL=0 for exactly H_BLANK cycles. Then if Y<V_ACTIVE-1: Y+1, X=0, → ACTIVE. Otherwise → VBLANK.
  - VBLANK: oDVAL=0 for V_BLANK·(H_ACTIVE+H_BLANK) cycles. On the last cycle: oFRAME_DONE=1 and oFrameCount+1. Then if the stop latch is set → IDLE and the latch clears. Otherwise → ACTIVE with X=Y=0, and iMODE/iLEVEL are re-latched.
- Patterns use the latched mode:
  - mode 0: LEVEL
  - mode 1: X[9:0]
  - mode 2: 1023 if X[3]^Y[3], else 0
  - mode 3: Y[9:0]
- iSTOP=1 in any non-IDLE state sets the stop latch. A frame is never truncated. iSTOP in IDLE is ignored.
- iSTART in a non-IDLE state is ignored. If iSTART and iSTOP are both high in IDLE, start wins; the stop is not latched.
- Mid-frame reset: everything returns to reset values immediately and asynchronously. oDVAL drops with no further pixels.
- X and Y counters are 16 bits. oX/oY hold their last value during blanking.

## Timing
- iSTART sampled high at edge k → pixel (0,0) visible with oDVAL=1 after edge k+1.
- Line period: H_ACTIVE+H_BLANK cycles.
- Frame period: (V_ACTIVE+V_BLANK)·(H_ACTIVE+H_BLANK) cycles. With defaults: 482·656 = 316192.
- Back-to-back frames: pixel (0,0) of the next frame follows the oFRAME_DONE cycle directly.
- oBUSY falls on the edge after the last VBLANK cycle of a stopped frame.

## Configuration
- PIX_GEN_STALL_EN defined:
  - Adds input iSTALL (1 bit).
  - In ACTIVE, iSTALL sampled high → next cycle oDVAL=0, oDATA=0, X held. The same pixel is re-emitted on the first cycle after iSTALL is sampled low.
  - iSTALL is ignored in HBLANK, VBLANK and IDLE; blanking counters always run.
  - iSTOP still sets the latch while stalled.
- Undefined: no iSTALL port. ACTIVE runs H_ACTIVE consecutive valid cycles with no gaps.

## Test plan
- Reset, then mode 1 and iSTART pulse → 640 valid cycles with oDATA 0..639, then exactly 16 cycles with oDVAL=0, then row 1 starting at oDATA 0.
- Mode 2, full frame → pixel (8,0)=1023, (0,0)=0, (8,8)=0. Exactly 307200 valid cycles. oFRAME_DONE pulses once, 316192 cycles after the start edge. oFrameCount=1.
- Mode 0, iLEVEL=0x155; iSTOP pulsed at row 200 → frame completes with all 307200 pixels =0x155, then IDLE. oBUSY=0, oFrameCount=1, no further oDVAL.
- iMODE changed 3→1 mid-frame → the current frame stays a vertical ramp (row 300 pixels =300); the next frame is a horizontal ramp.
- Reset asserted at pixel (100,50) → same cycle all outputs are 0. After release plus iSTART, the stream restarts at (0,0).
- PIX_GEN_STALL_EN, iSTALL held 5 cycles during pixel X=10 of row 0 → 5 invalid cycles, no pixel skipped or duplicated, and the line still contains 640 valid pixels 0..639.
